// File: rtl/rom_arbiter.sv
// Shares the character ROM between display (priority) and aux readers; ROM_ARB_STARVE_GUARD_EN adds an aux anti-starvation guard.
// Accept-to-valid is ROM_LATENCY+2 cycles with one issue per cycle; requesters stall by holding Req until they see Gnt.
module rom_arbiter #(
  parameter int ROM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic       pixelClk,
  input  logic       reset,
  input  logic       dispReq,
  input  logic [2:0] dispNum,
  input  logic [3:0] dispOffset,
  output logic       dispGnt,
  output logic       dispValid,
  output logic [7:0] dispByte,
  input  logic       auxReq,
  input  logic [2:0] auxNum,
  input  logic [3:0] auxOffset,
  output logic       auxGnt,
  output logic       auxValid,
  output logic [7:0] auxByte,
  output logic       romReadEn,
  output logic [2:0] romNum,
  output logic [3:0] romAddrOffset,
  input  logic [7:0] romByte
);

  typedef struct packed {
    logic vld;
    logic owner;
  } tag_t;

  localparam logic OWNER_DISP = 1'b0;
  localparam logic OWNER_AUX  = 1'b1;

  if (ROM_LATENCY < 0 || ROM_LATENCY > 3) begin : gBadLatency
    $error("rom_arbiter: ROM_LATENCY out of range");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : gBadStarveLimit
    $error("rom_arbiter: STARVE_LIMIT out of range");
  end

  logic auxWins;
  tag_t tagPipe [0:ROM_LATENCY];
  tag_t retTag;

`ifdef ROM_ARB_STARVE_GUARD_EN
  localparam logic [0:0] ST_NORMAL  = 1'b0;
  localparam logic [0:0] ST_STARVED = 1'b1;
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  logic [0:0] state;
  logic [7:0] starveCnt;
  logic [7:0] starveCntNext;

  assign auxWins = auxReq && (!dispReq || state == ST_STARVED);

  always_comb begin
    starveCntNext = starveCnt;
    if (!auxReq || auxGnt) begin
      starveCntNext = 8'd0;
    end else if (starveCnt != STARVE_MAX) begin
      starveCntNext = starveCnt + 8'd1;
    end
  end

  // Entering STARVED on the same edge the count saturates lets aux win the very next cycle.
  always_ff @(posedge pixelClk) begin
    if (reset) begin
      starveCnt <= 8'd0;
      state     <= ST_NORMAL;
    end else begin
      starveCnt <= starveCntNext;
      if (auxGnt) begin
        state <= ST_NORMAL;
      end else if (starveCntNext == STARVE_MAX) begin
        state <= ST_STARVED;
      end
    end
  end
`else
  assign auxWins = auxReq && !dispReq;
`endif

  assign auxGnt  = !reset && auxWins;
  assign dispGnt = !reset && dispReq && !auxWins;

  always_ff @(posedge pixelClk) begin
    if (reset) begin
      romReadEn     <= 1'b0;
      romNum        <= 3'd0;
      romAddrOffset <= 4'd0;
    end else begin
      romReadEn <= dispGnt || auxGnt;
      if (auxGnt) begin
        romNum        <= auxNum;
        romAddrOffset <= auxOffset;
      end else if (dispGnt) begin
        romNum        <= dispNum;
        romAddrOffset <= dispOffset;
      end
    end
  end

  // Owner tags travel alongside the read so the returned byte lands with the right requester.
  always_ff @(posedge pixelClk) begin
    if (reset) begin
      for (int k = 0; k <= ROM_LATENCY; k++) begin
        tagPipe[k] <= '0;
      end
    end else begin
      tagPipe[0] <= '{vld: dispGnt || auxGnt, owner: auxGnt};
      for (int k = 1; k <= ROM_LATENCY; k++) begin
        tagPipe[k] <= tagPipe[k-1];
      end
    end
  end

  assign retTag = tagPipe[ROM_LATENCY];

  always_ff @(posedge pixelClk) begin
    if (reset) begin
      dispValid <= 1'b0;
      auxValid  <= 1'b0;
      dispByte  <= 8'd0;
      auxByte   <= 8'd0;
    end else begin
      dispValid <= retTag.vld && retTag.owner == OWNER_DISP;
      auxValid  <= retTag.vld && retTag.owner == OWNER_AUX;
      if (retTag.vld && retTag.owner == OWNER_DISP) begin
        dispByte <= romByte;
      end
      if (retTag.vld && retTag.owner == OWNER_AUX) begin
        auxByte <= romByte;
      end
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter at default parameters with a one-cycle ROM model.
module tb_rom_arbiter;
  logic       pixelClk = 1'b0;
  logic       reset;
  logic       dispReq;
  logic [2:0] dispNum;
  logic [3:0] dispOffset;
  logic       dispGnt;
  logic       dispValid;
  logic [7:0] dispByte;
  logic       auxReq;
  logic [2:0] auxNum;
  logic [3:0] auxOffset;
  logic       auxGnt;
  logic       auxValid;
  logic [7:0] auxByte;
  logic       romReadEn;
  logic [2:0] romNum;
  logic [3:0] romAddrOffset;
  logic [7:0] romByte = 8'd0;

  int checks = 0;
  int errors = 0;

  rom_arbiter dut (
    .pixelClk(pixelClk), .reset(reset),
    .dispReq(dispReq), .dispNum(dispNum), .dispOffset(dispOffset),
    .dispGnt(dispGnt), .dispValid(dispValid), .dispByte(dispByte),
    .auxReq(auxReq), .auxNum(auxNum), .auxOffset(auxOffset),
    .auxGnt(auxGnt), .auxValid(auxValid), .auxByte(auxByte),
    .romReadEn(romReadEn), .romNum(romNum), .romAddrOffset(romAddrOffset),
    .romByte(romByte)
  );

  always #5 pixelClk = ~pixelClk;

  function automatic logic [7:0] romData(input logic [2:0] n, input logic [3:0] o);
    return {n, o, 1'b0} ^ 8'hA5;
  endfunction

  always @(posedge pixelClk) begin
    if (romReadEn) romByte <= romData(romNum, romAddrOffset);
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge pixelClk);
    #1;
  endtask

  task automatic sample;
    @(negedge pixelClk);
  endtask

  task automatic idle(input int n);
    dispReq = 1'b0;
    auxReq  = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 1'b1;
    dispReq = 1'b1; dispNum = 3'd0; dispOffset = 4'd0;
    auxReq  = 1'b1; auxNum  = 3'd0; auxOffset  = 4'd0;

    // reset: grants suppressed, registers cleared
    tick(); tick(); sample();
    checkVal("rst_dispGnt", dispGnt, 0);
    checkVal("rst_auxGnt", auxGnt, 0);
    checkVal("rst_romReadEn", romReadEn, 0);
    checkVal("rst_romNum", romNum, 0);
    checkVal("rst_romOff", romAddrOffset, 0);
    checkVal("rst_dispValid", dispValid, 0);
    checkVal("rst_auxValid", auxValid, 0);
    checkVal("rst_dispByte", dispByte, 0);
    checkVal("rst_auxByte", auxByte, 0);
    tick();
    reset = 1'b0;
    idle(2);

    // single display read
    dispReq = 1'b1; dispNum = 3'd3; dispOffset = 4'd5;
    sample();
    checkVal("single_dispGnt", dispGnt, 1);
    checkVal("single_auxGnt", auxGnt, 0);
    tick(); dispReq = 1'b0; sample();
    checkVal("single_readEn", romReadEn, 1);
    checkVal("single_romNum", romNum, 3);
    checkVal("single_romOff", romAddrOffset, 5);
    checkVal("single_valid_n1", dispValid, 0);
    tick(); sample();
    checkVal("single_readEn_n2", romReadEn, 0);
    checkVal("single_valid_n2", dispValid, 0);
    tick(); sample();
    checkVal("single_valid_n3", dispValid, 1);
    checkVal("single_byte", dispByte, romData(3'd3, 4'd5));
    checkVal("single_auxValid", auxValid, 0);
    tick(); sample();
    checkVal("single_valid_n4", dispValid, 0);
    checkVal("single_romNum_hold", romNum, 3);
    idle(3);

    // simultaneous requests: display first, then aux
    dispReq = 1'b1; dispNum = 3'd1; dispOffset = 4'd2;
    auxReq  = 1'b1; auxNum  = 3'd6; auxOffset  = 4'd9;
    sample();
    checkVal("sim_dispGnt", dispGnt, 1);
    checkVal("sim_auxGnt", auxGnt, 0);
    tick(); dispReq = 1'b0; sample();
    checkVal("sim_auxGnt_n1", auxGnt, 1);
    checkVal("sim_dispGnt_n1", dispGnt, 0);
    checkVal("sim_romNum_n1", romNum, 1);
    tick(); auxReq = 1'b0; sample();
    checkVal("sim_readEn_n2", romReadEn, 1);
    checkVal("sim_romNum_n2", romNum, 6);
    checkVal("sim_romOff_n2", romAddrOffset, 9);
    tick(); sample();
    checkVal("sim_dispValid_n3", dispValid, 1);
    checkVal("sim_auxValid_n3", auxValid, 0);
    checkVal("sim_dispByte", dispByte, romData(3'd1, 4'd2));
    tick(); sample();
    checkVal("sim_auxValid_n4", auxValid, 1);
    checkVal("sim_dispValid_n4", dispValid, 0);
    checkVal("sim_auxByte", auxByte, romData(3'd6, 4'd9));
    checkVal("sim_dispByte_hold", dispByte, romData(3'd1, 4'd2));
    idle(3);

    // back-to-back display reads, offsets 0..3
    for (int c = 0; c < 8; c++) begin
      dispReq = (c < 4); dispNum = 3'd2; dispOffset = 4'(c);
      sample();
      if (c < 4) checkVal($sformatf("b2b_gnt_%0d", c), dispGnt, 1);
      checkVal($sformatf("b2b_readEn_%0d", c), romReadEn, (c >= 1 && c <= 4));
      checkVal($sformatf("b2b_valid_%0d", c), dispValid, (c >= 3 && c <= 6));
      if (c >= 3 && c <= 6)
        checkVal($sformatf("b2b_byte_%0d", c), dispByte, romData(3'd2, 4'(c - 3)));
      tick();
    end
    idle(3);

`ifdef ROM_ARB_STARVE_GUARD_EN
    // both held: aux wins once every 9 cycles
    dispReq = 1'b1; auxReq = 1'b1;
    for (int c = 0; c < 27; c++) begin
      sample();
      checkVal($sformatf("starve_auxGnt_%0d", c), auxGnt, (c % 9 == 8));
      checkVal($sformatf("starve_dispGnt_%0d", c), dispGnt, (c % 9 != 8));
      tick();
    end
`else
    // both held: strict display priority
    dispReq = 1'b1; auxReq = 1'b1;
    for (int c = 0; c < 20; c++) begin
      sample();
      checkVal($sformatf("prio_auxGnt_%0d", c), auxGnt, 0);
      checkVal($sformatf("prio_dispGnt_%0d", c), dispGnt, 1);
      tick();
    end
`endif
    idle(5);

    // reset while a read is in flight
    dispReq = 1'b1; dispNum = 3'd4; dispOffset = 4'd7;
    sample();
    checkVal("mid_gnt_n0", dispGnt, 1);
    tick(); reset = 1'b1; sample();
    checkVal("mid_dispGnt_rst", dispGnt, 0);
    checkVal("mid_auxGnt_rst", auxGnt, 0);
    tick(); reset = 1'b0; dispReq = 1'b0; sample();
    checkVal("mid_readEn_n2", romReadEn, 0);
    checkVal("mid_romNum_n2", romNum, 0);
    checkVal("mid_valid_n2", dispValid, 0);
    checkVal("mid_byte_n2", dispByte, 0);
    checkVal("mid_auxByte_n2", auxByte, 0);
    tick(); dispReq = 1'b1; dispNum = 3'd5; dispOffset = 4'd1; sample();
    checkVal("mid_gnt_n3", dispGnt, 1);
    checkVal("mid_valid_n3", dispValid, 0);
    tick(); dispReq = 1'b0; sample();
    checkVal("mid_readEn_n4", romReadEn, 1);
    checkVal("mid_romNum_n4", romNum, 5);
    checkVal("mid_valid_n4", dispValid, 0);
    tick(); sample();
    checkVal("mid_valid_n5", dispValid, 0);
    tick(); sample();
    checkVal("mid_valid_n6", dispValid, 1);
    checkVal("mid_byte_n6", dispByte, romData(3'd5, 4'd1));
    idle(3);

    // aux request cancelled under display load
    for (int c = 0; c < 10; c++) begin
      dispReq = (c < 4); dispNum = 3'd0; dispOffset = 4'd0;
      auxReq  = (c < 2); auxNum  = 3'd7; auxOffset  = 4'd15;
      sample();
      checkVal($sformatf("cancel_auxGnt_%0d", c), auxGnt, 0);
      checkVal($sformatf("cancel_auxValid_%0d", c), auxValid, 0);
      if (c >= 1) checkVal($sformatf("cancel_romNum_%0d", c), romNum, 0);
`ifdef ROM_ARB_STARVE_GUARD_EN
      if (c == 3) checkVal("cancel_starveCnt", dut.starveCnt, 0);
`endif
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
